// File: rtl/audio_tdm_out.sv
// audio_tdm_out: serial DAC output stage for the synth engine.
// Sends CHANNELS samples per frame on one data line, in I2S (LR pairs,
// one-bit data delay) or TDM (one-bit frame pulse, no delay) format.
// Derives BCLK and LRCK from AUD_XCK. Samples pass through a one-deep
// valid/ready holding register into a shadow register at each frame boundary.
// Optional build macro AUDIO_TDM_MUTE_ON_UNDERRUN_EN: a frame that starts
// with the holding register empty goes out silent instead of repeating.

// Maps one sample onto the slot bits in transmit order: slot[k] is sent
// k BCLKs into the slot, MSB first, with zero padding after the sample.
module audio_tdm_slot #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SLOT_W-1:0]   slot
);
  for (genvar k = 0; k < SLOT_W; k++) begin : g_bit
    if (k < SAMPLE_W) begin : g_data
      assign slot[k] = sample[SAMPLE_W-1-k];
    end else begin : g_pad
      assign slot[k] = 1'b0;
    end
  end
endmodule

module audio_tdm_out #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                         AUD_XCK,
  input  logic                         reset_reg_N,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         mode,
  output logic                         AUD_BCLK,
  output logic                         AUD_DACLRCK,
  output logic                         AUD_DACDAT,
  output logic                         frame_start,
  output logic                         underrun
);
  localparam int F  = CHANNELS * SLOT_W;
  localparam int BW = $clog2(F);
  localparam int DW = $clog2(BCLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(F - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(F / 2);

  localparam logic [0:0] MODE_I2S = 1'b0;
  localparam logic [0:0] MODE_TDM = 1'b1;

  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          div_wrap, boundary, accept;

  logic [CHANNELS-1:0][SAMPLE_W-1:0] hold_q, hold_nxt;
  logic [CHANNELS-1:0][SAMPLE_W-1:0] shadow_q, shadow_nxt;
  logic [0:0]    mode_q, mode_nxt;
  logic          ready_nxt;

  // Transmit-order bit streams of the current and the next-cycle shadow.
  logic [F-1:0]  stream_cur, stream_nxt;
  logic          dat_nxt, lrck_nxt, bclk_nxt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    audio_tdm_slot #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W)) u_cur (
      .sample (shadow_q[c]),
      .slot   (stream_cur[c*SLOT_W +: SLOT_W])
    );
    audio_tdm_slot #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W)) u_nxt (
      .sample (shadow_nxt[c]),
      .slot   (stream_nxt[c*SLOT_W +: SLOT_W])
    );
  end

  assign div_wrap = (div_cnt == DIV_LAST);
  assign div_nxt  = div_wrap ? '0 : div_cnt + DW'(1);
  assign bit_nxt  = !div_wrap ? bit_cnt : ((bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1));
  assign boundary = div_wrap && (bit_cnt == BIT_LAST);
  assign accept   = sample_valid && sample_ready;
  assign bclk_nxt = (div_nxt >= DIV_HALF);

  // Holding/shadow handoff, mode latch and next serial bit.
  always_comb begin
    hold_nxt   = hold_q;
    shadow_nxt = shadow_q;
    mode_nxt   = mode_q;
    ready_nxt  = sample_ready;
    if (accept) begin
      hold_nxt  = sample_in;
      ready_nxt = 1'b0;
    end
    if (boundary) begin
      mode_nxt = mode;
      if (!sample_ready) begin
        shadow_nxt = hold_q;
        ready_nxt  = 1'b1;
      end else begin
`ifdef AUDIO_TDM_MUTE_ON_UNDERRUN_EN
        shadow_nxt = '0;
`else
        shadow_nxt = shadow_q;
`endif
      end
    end
    // I2S bit 0 carries the last bit of the outgoing frame, so it is read
    // from the shadow before it reloads; TDM bit 0 already uses the new one.
    if (mode_nxt == MODE_TDM) begin
      dat_nxt  = stream_nxt[bit_nxt];
      lrck_nxt = (bit_nxt == BIT_LAST);
    end else begin
      dat_nxt  = (bit_nxt == '0) ? stream_cur[F-1] : stream_cur[bit_nxt - BW'(1)];
      lrck_nxt = (bit_nxt >= BIT_HALF);
    end
  end

  // Divider, bit counter, sample buffers and status pulses.
  always_ff @(posedge AUD_XCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      hold_q       <= '0;
      shadow_q     <= '0;
      mode_q       <= MODE_I2S;
      sample_ready <= 1'b1;
      AUD_BCLK     <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      bit_cnt      <= bit_nxt;
      hold_q       <= hold_nxt;
      shadow_q     <= shadow_nxt;
      mode_q       <= mode_nxt;
      sample_ready <= ready_nxt;
      AUD_BCLK     <= bclk_nxt;
      frame_start  <= boundary;
      underrun     <= boundary && sample_ready;
    end
  end

  // Data and LRCK move only on the BCLK falling edge.
  always_ff @(posedge AUD_XCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      AUD_DACDAT  <= 1'b0;
      AUD_DACLRCK <= 1'b0;
    end else if (div_wrap) begin
      AUD_DACDAT  <= dat_nxt;
      AUD_DACLRCK <= lrck_nxt;
    end
  end
endmodule

// File: tb/tb_audio_tdm_out.sv
// Bench for audio_tdm_out: a cycle-level reference model driven from
// frame/bit arithmetic, a directed I2S vector table, an 8-channel TDM
// instance, and random traffic.
module tb_audio_tdm_out;
  localparam int D   = 4;
  localparam int SW  = 24;
  localparam int SL  = 32;
  localparam int CH  = 2;
  localparam int F   = CH * SL;
  localparam int FD  = F * D;
  localparam int CH2 = 8;
  localparam int F2  = CH2 * SL;
  localparam int FD2 = F2 * D;
  localparam int WW  = CH2 * SW;

  logic AUD_XCK = 1'b0;
  logic reset_reg_N;
  logic [CH*SW-1:0] sample_in;
  logic sample_valid, sample_ready, mode;
  logic AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun;
  logic [CH2*SW-1:0] sample_in2;
  logic sample_valid2, sample_ready2, mode2;
  logic bclk2, lrck2, dat2, frame_start2, underrun2;

  int errors = 0;
  int checks = 0;
  int n = 0;
  bit chk_en = 1'b0;

  // Model state: frame contents and handshake, stepped once per AUD_XCK edge.
  logic [CH*SW-1:0] m_hold, m_cur, m_prev;
  logic m_full, m_mode, m_fs, m_ur, m_acc;

  typedef struct { int b; logic dat; logic lrck; } vec_t;
  vec_t tbl[$];

  always #5 AUD_XCK = ~AUD_XCK;

  audio_tdm_out #(.CHANNELS(CH), .SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(D)) u_dut (
    .AUD_XCK(AUD_XCK), .reset_reg_N(reset_reg_N), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .mode(mode),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .frame_start(frame_start), .underrun(underrun)
  );

  audio_tdm_out #(.CHANNELS(CH2), .SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(D)) u_dut8 (
    .AUD_XCK(AUD_XCK), .reset_reg_N(reset_reg_N), .sample_in(sample_in2),
    .sample_valid(sample_valid2), .sample_ready(sample_ready2), .mode(mode2),
    .AUD_BCLK(bclk2), .AUD_DACLRCK(lrck2), .AUD_DACDAT(dat2),
    .frame_start(frame_start2), .underrun(underrun2)
  );

  // Bit s of a frame in transmit order: slot s/SL, MSB first, zero padded.
  function automatic logic stream_bit(input logic [WW-1:0] sh, input int s);
    int c, k;
    c = s / SL;
    k = s % SL;
    if (k >= SW) return 1'b0;
    return sh[c*SW + SW-1-k];
  endfunction

  function automatic logic [5:0] outs();
    return {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun, sample_ready};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got=0x%0h want=0x%0h", name, n, got, want);
    end
  endtask

  task automatic wait_n(input int t);
    while (n < t) @(negedge AUD_XCK);
  endtask

  task automatic add_vec(input int b, input logic d, input logic l);
    vec_t v;
    v.b = b; v.dat = d; v.lrck = l;
    tbl.push_back(v);
  endtask

  task automatic model_proc();
    forever begin
      @(posedge AUD_XCK or negedge reset_reg_N);
      if (!reset_reg_N) begin
        n = 0; m_hold = '0; m_cur = '0; m_prev = '0;
        m_full = 1'b0; m_mode = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
      end else begin
        n++;
        m_fs = 1'b0;
        m_ur = 1'b0;
        m_acc = sample_valid && !m_full;
        if (n % FD == 0) begin
          m_fs = 1'b1;
          m_prev = m_cur;
          m_mode = mode;
          if (m_full) begin
            m_cur = m_hold;
            m_full = 1'b0;
          end else begin
            m_ur = 1'b1;
`ifdef AUDIO_TDM_MUTE_ON_UNDERRUN_EN
            m_cur = '0;
`endif
          end
        end
        if (m_acc) begin
          m_hold = sample_in;
          m_full = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor();
    int b;
    logic ed, el, eb;
    forever begin
      @(negedge AUD_XCK);
      if (reset_reg_N && chk_en) begin
        b = (n / D) % F;
        if (m_mode) ed = stream_bit(WW'(m_cur), b);
        else if (b == 0) ed = stream_bit(WW'(m_prev), F-1);
        else ed = stream_bit(WW'(m_cur), b-1);
        el = m_mode ? (b == F-1) : (b >= F/2);
        eb = ((n % D) >= D/2);
        check("cycle_model", int'(outs()), int'({eb, el, ed, m_fs, m_ur, !m_full}));
      end
    end
  endtask

  initial begin
    int t, cnt, k8;
    logic ed;
    reset_reg_N = 1'b0;
    sample_in = '0; sample_valid = 1'b0; mode = 1'b0;
    sample_in2 = '0; sample_valid2 = 1'b0; mode2 = 1'b0;
    m_hold = '0; m_cur = '0; m_prev = '0;
    m_full = 1'b0; m_mode = 1'b0; m_fs = 1'b0; m_ur = 1'b0; m_acc = 1'b0;

    // L=0x800001, R=0x7FFFFE, I2S one-bit delay: DAT at bit b = stream bit b-1.
    add_vec(0, 1'b0, 1'b0);  add_vec(1, 1'b1, 1'b0);  add_vec(2, 1'b0, 1'b0);
    add_vec(12, 1'b0, 1'b0); add_vec(23, 1'b0, 1'b0); add_vec(24, 1'b1, 1'b0);
    add_vec(25, 1'b0, 1'b0); add_vec(31, 1'b0, 1'b0); add_vec(32, 1'b0, 1'b1);
    add_vec(33, 1'b0, 1'b1); add_vec(34, 1'b1, 1'b1); add_vec(45, 1'b1, 1'b1);
    add_vec(55, 1'b1, 1'b1); add_vec(56, 1'b0, 1'b1); add_vec(57, 1'b0, 1'b1);
    add_vec(63, 1'b0, 1'b1);

    fork model_proc(); join_none
    repeat (3) @(negedge AUD_XCK);
    check("reset_initial", int'(outs()), 1);
    check("reset_initial_8ch", int'({bclk2, lrck2, dat2, frame_start2, underrun2, sample_ready2}), 1);
    reset_reg_N = 1'b1;
    chk_en = 1'b1;
    fork monitor(); join_none

    sample_in = {24'h7FFFFE, 24'h800001};
    sample_valid = 1'b1;
    for (int k = 0; k < CH2; k++) sample_in2[k*SW +: SW] = SW'(k << 16);
    sample_valid2 = 1'b1;
    mode2 = 1'b1;
    @(negedge AUD_XCK);
    sample_valid = 1'b0;
    sample_valid2 = 1'b0;

    fork
      begin : br_i2s
        for (int fr = 1; fr <= 2; fr++) begin
          foreach (tbl[i]) begin
            wait_n(fr*FD + tbl[i].b*D + 1);
            ed = tbl[i].dat;
`ifdef AUDIO_TDM_MUTE_ON_UNDERRUN_EN
            if (fr == 2) ed = 1'b0;
`endif
            check(fr == 1 ? "i2s_frame" : "i2s_repeat",
                  int'({AUD_DACLRCK, AUD_DACDAT}), int'({tbl[i].lrck, ed}));
          end
        end
        // Two valid samples inside one frame.
        wait_n(3*FD + 20);
        sample_in = {24'h123456, 24'hABCDEF};
        sample_valid = 1'b1;
        @(negedge AUD_XCK);
        check("ready_drop", int'(sample_ready), 0);
        sample_in = {24'h0F0F0F, 24'hF0F0F0};
        t = 0;
        while (!sample_ready && t < 2*FD) begin
          @(negedge AUD_XCK);
          t++;
        end
        check("ready_at_boundary", int'({sample_ready, (n % FD) == 0}), 3);
        @(negedge AUD_XCK);
        check("second_accept", int'(sample_ready), 0);
        sample_valid = 1'b0;
        cnt = 0;
        repeat (2*FD) begin
          @(negedge AUD_XCK);
          cnt += int'(frame_start);
        end
        check("frame_start_count", cnt, 2);
      end
      begin : br_tdm8
        wait_n(FD2);
        check("tdm8_boundary", int'({frame_start2, underrun2, sample_ready2}), 5);
        for (int b = 0; b < F2; b++) begin
          wait_n(FD2 + b*D + 1);
          check("tdm8_bit", int'({bclk2, lrck2, dat2}),
                int'({1'b0, b == F2-1, stream_bit(sample_in2, b)}));
        end
      end
    join

    // Mode toggled mid-frame takes effect at the next frame.
    k8 = n / FD + 1;
    wait_n(k8*FD + 10*D + 1);
    mode = 1'b1;
    wait_n(k8*FD + 40*D + 1);
    check("i2s_continues", int'(AUD_DACLRCK), 1);
    wait_n((k8+1)*FD + 40*D + 1);
    check("tdm_lrck_low", int'(AUD_DACLRCK), 0);
    wait_n((k8+1)*FD + 63*D + 1);
    check("tdm_lrck_high", int'(AUD_DACLRCK), 1);

    // Reset in the middle of a frame.
    wait_n((k8+2)*FD + 17*D + 2);
    #3 reset_reg_N = 1'b0;
    #1 check("reset_mid", int'(outs()), 1);
    mode = 1'b0;
    repeat (2) @(negedge AUD_XCK);
    reset_reg_N = 1'b1;
    wait_n(2);
    check("bclk_rise", int'(AUD_BCLK), 1);
    wait_n(4);
    check("bclk_fall", int'(AUD_BCLK), 0);
    t = 0;
    while (!frame_start && t < 2*FD) begin
      @(negedge AUD_XCK);
      t++;
    end
    check("frame_len", n, FD);
    check("first_underrun", int'(underrun), 1);

    // Random traffic, mode flips and underruns against the model.
    for (int fr = 0; fr < 20; fr++) begin
      int rate;
      rate = int'($urandom_range(0, 6));
      repeat (FD) begin
        @(negedge AUD_XCK);
        sample_valid = (int'($urandom_range(0, 99)) < rate);
        sample_in = {24'($urandom), 24'($urandom)};
        if ($urandom_range(0, 299) == 0) mode = ~mode;
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog n=%0d got=timeout want=finish", n);
    $fatal(1, "timeout");
  end
endmodule
